// File: rtl/hlsm_loop_acc.sv
// hlsm_loop_acc
//   Scheduled state machine that runs one counted loop per request:
//     for (i = loop_start; i < loop_end; i++) { d = a + b*i; z += d; if (d > c) x++; }
//   A Start/Done handshake is used. Busy is high whenever the FSM is not in IDLE.
//
// Parameters
//   DATAWIDTH : width of a, b, c, z, x and the internal d. Must be greater than CNTWIDTH.
//   CNTWIDTH  : width of loop_start, loop_end and the loop variable i (signed).
//
// Ports
//   Clk        in   clock, rising edge
//   Rst        in   synchronous active-low reset
//   Start      in   request, only sampled in IDLE
//   a, b, c    in   signed operands (b multiplies i, c is the compare threshold)
//   loop_start in   signed initial value of i
//   loop_end   in   signed exclusive bound of i
//   z          out  signed accumulated sum
//   x          out  number of iterations with d > c
//   Done       out  one-cycle completion pulse
//   Busy       out  high in every state except IDLE
//
// Build option
//   HLSM_LOOP_ACC_SATURATE_EN : when defined, z + d saturates to the signed DATAWIDTH
//   limits instead of wrapping. The d computation always wraps.

module hlsm_loop_acc #(
   parameter int unsigned DATAWIDTH = 32,
   parameter int unsigned CNTWIDTH  = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Start,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [DATAWIDTH-1:0] c,
   input  logic [CNTWIDTH-1:0]  loop_start,
   input  logic [CNTWIDTH-1:0]  loop_end,
   output logic [DATAWIDTH-1:0] z,
   output logic [DATAWIDTH-1:0] x,
   output logic                 Done,
   output logic                 Busy
);

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StChk,
      StBody1,
      StBody2,
      StInc,
      StFinal
   } state_e;

   state_e state_q, state_d;

   // Operands latched on the accepted Start; the ports are don't-care afterwards.
   logic [DATAWIDTH-1:0] a_q, a_d;
   logic [DATAWIDTH-1:0] b_q, b_d;
   logic [DATAWIDTH-1:0] c_q, c_d;
   logic [CNTWIDTH-1:0]  start_q, start_d;
   logic [CNTWIDTH-1:0]  end_q, end_d;

   // Loop state and results.
   logic [CNTWIDTH-1:0]  i_q, i_d;
   logic [DATAWIDTH-1:0] d_q, d_d;
   logic [DATAWIDTH-1:0] z_q, z_d;
   logic [DATAWIDTH-1:0] x_q, x_d;

   // Datapath terms.
   logic [DATAWIDTH-1:0] i_ext;
   logic [DATAWIDTH-1:0] prod;
   logic [DATAWIDTH-1:0] d_calc;
   logic [DATAWIDTH-1:0] z_sum;
   logic                 d_gt_c;
   logic                 loop_more;

   //------------------------------------------------------------------
   // Datapath arithmetic
   //------------------------------------------------------------------
   always_comb begin
      i_ext     = {{(DATAWIDTH - CNTWIDTH){i_q[CNTWIDTH-1]}}, i_q};
      // Signed multiply evaluated at DATAWIDTH keeps only the low bits (two's-complement wrap).
      prod      = DATAWIDTH'($signed(b_q) * $signed(i_ext));
      d_calc    = a_q + prod;
      d_gt_c    = $signed(d_q) > $signed(c_q);
      loop_more = $signed(i_q) < $signed(end_q);
   end

`ifdef HLSM_LOOP_ACC_SATURATE_EN
   logic [DATAWIDTH:0] sum_wide;

   always_comb begin
      sum_wide = {z_q[DATAWIDTH-1], z_q} + {d_q[DATAWIDTH-1], d_q};
      // Top two bits disagree only on signed overflow; the extra bit holds the true sign.
      if (sum_wide[DATAWIDTH] != sum_wide[DATAWIDTH-1]) begin
         if (sum_wide[DATAWIDTH]) begin
            z_sum = {1'b1, {(DATAWIDTH - 1){1'b0}}};
         end else begin
            z_sum = {1'b0, {(DATAWIDTH - 1){1'b1}}};
         end
      end else begin
         z_sum = sum_wide[DATAWIDTH-1:0];
      end
   end
`else
   always_comb begin
      z_sum = z_q + d_q;
   end
`endif

   //------------------------------------------------------------------
   // Next-state and register updates
   //------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      start_d = start_q;
      end_d   = end_q;
      i_d     = i_q;
      d_d     = d_q;
      z_d     = z_q;
      x_d     = x_q;

      unique case (state_q)
         StIdle: begin
            if (Start) begin
               a_d     = a;
               b_d     = b;
               c_d     = c;
               start_d = loop_start;
               end_d   = loop_end;
               state_d = StInit;
            end
         end
         StInit: begin
            z_d     = '0;
            x_d     = '0;
            i_d     = start_q;
            state_d = StChk;
         end
         StChk: begin
            state_d = loop_more ? StBody1 : StFinal;
         end
         StBody1: begin
            d_d     = d_calc;
            state_d = StBody2;
         end
         StBody2: begin
            z_d = z_sum;
            if (d_gt_c) begin
               x_d = x_q + DATAWIDTH'(1);
            end
            state_d = StInc;
         end
         StInc: begin
            // Cannot overflow: CHK only lets i through while i < loop_end.
            i_d     = i_q + CNTWIDTH'(1);
            state_d = StChk;
         end
         StFinal: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   //------------------------------------------------------------------
   // State register
   //------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   //------------------------------------------------------------------
   // Datapath registers
   //------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         start_q <= '0;
         end_q   <= '0;
         i_q     <= '0;
         d_q     <= '0;
         z_q     <= '0;
         x_q     <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         start_q <= start_d;
         end_q   <= end_d;
         i_q     <= i_d;
         d_q     <= d_d;
         z_q     <= z_d;
         x_q     <= x_d;
      end
   end

   //------------------------------------------------------------------
   // Outputs (Moore decode, so reset forces Done and Busy low)
   //------------------------------------------------------------------
   always_comb begin
      z    = z_q;
      x    = x_q;
      Done = (state_q == StFinal);
      Busy = (state_q != StIdle);
   end

endmodule

// File: tb/tb_hlsm_loop_acc.sv
module tb_hlsm_loop_acc;

   logic               Clk;
   logic               Rst;

   // Default-width instance
   logic               Start;
   logic signed [31:0] a, b, c;
   logic signed [7:0]  loop_start, loop_end;
   logic signed [31:0] z, x;
   logic               Done, Busy;

   // Narrow instance for overflow behaviour
   logic               s_start;
   logic signed [7:0]  s_a, s_b, s_c;
   logic signed [3:0]  s_ls, s_le;
   logic signed [7:0]  s_z, s_x;
   logic               s_done, s_busy;

   int errors = 0;
   int checks = 0;

   hlsm_loop_acc #(
      .DATAWIDTH(32),
      .CNTWIDTH (8)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .a         (a),
      .b         (b),
      .c         (c),
      .loop_start(loop_start),
      .loop_end  (loop_end),
      .z         (z),
      .x         (x),
      .Done      (Done),
      .Busy      (Busy)
   );

   hlsm_loop_acc #(
      .DATAWIDTH(8),
      .CNTWIDTH (4)
   ) dut_small (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (s_start),
      .a         (s_a),
      .b         (s_b),
      .c         (s_c),
      .loop_start(s_ls),
      .loop_end  (s_le),
      .z         (s_z),
      .x         (s_x),
      .Done      (s_done),
      .Busy      (s_busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Issues one request with Start sampled at edge 0, then samples #1 after each edge.
   // extra_start_edge > 0 pulses Start again so it is sampled at that edge.
   task automatic run_op(input string name,
                         input logic signed [31:0] ia, input logic signed [31:0] ib,
                         input logic signed [31:0] ic,
                         input logic signed [7:0] ils, input logic signed [7:0] ile,
                         input logic signed [31:0] exp_z, input logic signed [31:0] exp_x,
                         input int exp_edge, input int extra_start_edge);
      int done_edge;
      done_edge = -1;
      @(negedge Clk);
      a = ia; b = ib; c = ic; loop_start = ils; loop_end = ile;
      Start = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      // Scramble the ports to prove the operands were latched.
      a = 32'h5a5a_1234; b = -32'sd77; c = 32'sd999; loop_start = -8'sd100; loop_end = 8'sd100;
      for (int k = 1; k <= exp_edge + 20; k++) begin
         @(posedge Clk);
         #1;
         if (k == 1) begin
            checks++;
            if (Busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy_after_start: got %b want 1", name, Busy);
            end
         end
         if (Done === 1'b1) begin
            done_edge = k;
            break;
         end
         Start = (extra_start_edge > 0 && k == extra_start_edge - 1);
      end
      Start = 1'b0;
      checks++;
      if (done_edge != exp_edge) begin
         errors++;
         $display("FAIL %s done_edge: got %0d want %0d", name, done_edge, exp_edge);
      end
      checks++;
      if (z !== exp_z) begin
         errors++;
         $display("FAIL %s z: got %0d want %0d", name, z, exp_z);
      end
      checks++;
      if (x !== exp_x) begin
         errors++;
         $display("FAIL %s x: got %0d want %0d", name, x, exp_x);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done: got done=%b busy=%b want done=0 busy=0", name, Done, Busy);
      end
      checks++;
      if (z !== exp_z || x !== exp_x) begin
         errors++;
         $display("FAIL %s hold: got z=%0d x=%0d want z=%0d x=%0d", name, z, x, exp_z, exp_x);
      end
   endtask

   task automatic test_reset;
      Rst = 1'b0; Start = 1'b0; s_start = 1'b0;
      a = '0; b = '0; c = '0; loop_start = '0; loop_end = '0;
      s_a = '0; s_b = '0; s_c = '0; s_ls = '0; s_le = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      checks++;
      if (z !== 32'sd0 || x !== 32'sd0 || Done !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got z=%0d x=%0d done=%b busy=%b want all 0", z, x, Done, Busy);
      end
      checks++;
      if (s_z !== 8'sd0 || s_x !== 8'sd0 || s_done !== 1'b0 || s_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state_small: got z=%0d x=%0d done=%b busy=%b want all 0",
                  s_z, s_x, s_done, s_busy);
      end
   endtask

   task automatic test_basic;
      // d = 3,5,7,9 -> z = 24, d > 5 twice
      run_op("basic", 3, 2, 5, 0, 4, 24, 2, 18, 0);
   endtask

   task automatic test_zero_trip;
      run_op("zero_trip", 7, 7, 0, 2, -1, 0, 0, 2, 0);
   endtask

   task automatic test_signed;
      // d = -10,-9,-8 -> z = -27, none strictly above -8
      run_op("signed", -10, 1, -8, 0, 3, -27, 0, 14, 0);
      // i = -2,-1,0 with b = -3 -> d = 6,3,0 -> z = 9, two above 0
      run_op("neg_index", 0, -3, 0, -2, 1, 9, 2, 14, 0);
   endtask

   task automatic test_start_while_busy;
      run_op("start_busy", 3, 2, 5, 0, 4, 24, 2, 18, 5);
   endtask

   task automatic test_reset_mid_run;
      int done_seen;
      done_seen = 0;
      @(negedge Clk);
      a = 3; b = 2; c = 5; loop_start = 0; loop_end = 4;
      Start = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge Clk);
         #1;
         if (Done === 1'b1) done_seen++;
         if (k == 6) Rst = 1'b0;
      end
      checks++;
      if (z !== 32'sd0 || x !== 32'sd0 || Busy !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_run: got z=%0d x=%0d busy=%b done=%b want all 0",
                  z, x, Busy, Done);
      end
      Rst = 1'b1;
      for (int k = 0; k < 25; k++) begin
         @(posedge Clk);
         #1;
         if (Done === 1'b1 || Busy === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         errors++;
         $display("FAIL reset_no_done: got %0d active cycles want 0", done_seen);
      end
      run_op("after_reset", 3, 2, 5, 0, 4, 24, 2, 18, 0);
   endtask

   task automatic test_overflow;
      logic signed [7:0] exp_z;
      int done_edge;
`ifdef HLSM_LOOP_ACC_SATURATE_EN
      exp_z = 8'sd127;
`else
      exp_z = -8'sd56;
`endif
      done_edge = -1;
      @(negedge Clk);
      s_a = 8'sd100; s_b = 8'sd0; s_c = 8'sd0; s_ls = 4'sd0; s_le = 4'sd2;
      s_start = 1'b1;
      @(posedge Clk);
      #1;
      s_start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge Clk);
         #1;
         if (s_done === 1'b1) begin
            done_edge = k;
            break;
         end
      end
      checks++;
      if (done_edge != 10) begin
         errors++;
         $display("FAIL overflow done_edge: got %0d want 10", done_edge);
      end
      checks++;
      if (s_z !== exp_z) begin
         errors++;
         $display("FAIL overflow z: got %0d want %0d", s_z, exp_z);
      end
      checks++;
      if (s_x !== 8'sd2) begin
         errors++;
         $display("FAIL overflow x: got %0d want 2", s_x);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_trip();
      test_signed();
      test_start_while_busy();
      test_reset_mid_run();
      test_overflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hlsm_loop_acc.md
Name: hlsm_loop_acc

Overview:
- Parametrised, HLS-style scheduled state machine with a Start/Done handshake.
- Executes one counted for-loop per request. Loop body: `d = a + b*i; z += d; if (d > c) x++`.
- Successor to the fixed-width, straight-line generated HLSM blocks. Adds:
  - parametrised data and loop-counter widths;
  - a real loop with a runtime trip count;
  - a Busy flag;
  - optional saturating accumulation.
- Sits between a host controller and the datapath it schedules.

Parameters:
- DATAWIDTH, 32, width of a, b, c, z, x and internal d. Must be greater than CNTWIDTH.
- CNTWIDTH, 8, width of the loop bounds and the loop variable i (signed).

Ports:
- Clk  input  1  clock; all logic on the rising edge.
- Rst  input  1  synchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- a  input  DATAWIDTH  signed operand.
- b  input  DATAWIDTH  signed operand (multiplier of i).
- c  input  DATAWIDTH  signed compare threshold.
- loop_start  input  CNTWIDTH  signed initial value of i.
- loop_end  input  CNTWIDTH  signed exclusive bound; loop runs while i < loop_end.
- z  output  DATAWIDTH  signed accumulated sum.
- x  output  DATAWIDTH  count of iterations with d > c.
- Done  output  1  one-cycle completion pulse.
- Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset:
  - Rst low at a rising edge forces IDLE and clears z, x, Done, Busy, d and i to 0.
  - Reset has priority over all other activity.
  - Reset mid-operation aborts the loop; no Done is issued.
- States: IDLE, INIT, CHK, BODY1, BODY2, INC, FINAL.
- IDLE:
  - Start high at edge k=0 latches a, b, c, loop_start and loop_end into internal registers, then goes to INIT.
  - Inputs are don't-care after k=0.
- INIT: z=0, x=0, i=loop_start; go to CHK.
- CHK: if i < loop_end (signed, CNTWIDTH) go to BODY1, else go to FINAL.
- BODY1: d = a + b*sext(i). Product and sum are signed and truncated to DATAWIDTH (two's-complement wrap).
- BODY2: z = z + d (wrap, unless the optional feature is enabled); if d > c (signed), x = x + 1.
- INC: i = i + 1; go to CHK.
- FINAL: Done=1 for exactly one cycle; go to IDLE. Done is 0 in all other states.
- Trip count: N = max(0, loop_end − loop_start). loop_end ≤ loop_start gives N=0, z=0, x=0.
- Timing: Done is high in the cycle after edge 2+4N, counted from the Start-sampling edge k=0. Total latency is 3+4N cycles.
- Busy is high from the cycle after k=0 through the FINAL cycle inclusive.
- z and x hold their final values after Done until the next accepted Start clears them in INIT.
- Start while Busy is ignored and not queued. Start held high through FINAL is re-accepted only once the FSM is back in IDLE.
- i never wraps: the loop exits before the increment that would overflow, because i < loop_end ≤ max.

Optional Feature:
- Macro: HLSM_LOOP_ACC_SATURATE_EN.
- Defined: the BODY2 accumulate z + d saturates to the signed DATAWIDTH limits, max 2^(DATAWIDTH−1)−1 and min −2^(DATAWIDTH−1). Once saturated, z stays saturated until further terms move it back within range.
- Undefined: z wraps modulo 2^DATAWIDTH.
- The d computation always wraps in both modes. x is unaffected.

Test Plan:
- Basic loop: a=3, b=2, c=5, loop_start=0, loop_end=4, Start pulsed at edge 0 → d=3,5,7,9; Done high after edge 18; z=24, x=2; Busy low again after Done.
- Zero trip: loop_start=2, loop_end=−1 → Done high after edge 2; z=0, x=0.
- Signed values: a=−10, b=1, c=−8, loop 0..3 → z=−27, x=0; Done after edge 14.
- Overflow, DATAWIDTH=8, CNTWIDTH=4: a=100, b=0, c=0, loop 0..2:
  - without the macro → z=−56, x=2;
  - with HLSM_LOOP_ACC_SATURATE_EN → z=127, x=2.
- Reset and Start while busy:
  - Start pulses again at edge 5 of the basic run → ignored; results and timing are identical to the basic loop.
  - Rst low at edge 7 of a new run → z=0, x=0, Busy=0, no Done.
  - A fresh Start then completes normally.
